// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the accumulator data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned RD_LAT_DEF    = 2;
  localparam int unsigned MAX_BURST_DEF = 8;

  // Burst counter is wide enough for MAX_BURST up to 255.
  localparam int unsigned BURST_CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    OWN_A = ST_OWN_A,
    OWN_B = ST_OWN_B
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // One entry of the in-flight read tracker.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports plus the memory pins of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = mem_port_arbiter_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = mem_port_arbiter_pkg::DATA_W_DEF
);

  logic              ReqA;
  logic              LockA;
  logic [ADDR_W-1:0] AddrA;
  logic              WeA;
  logic [DATA_W-1:0] WDataA;
  logic              GntA;
  logic              RValidA;

  logic              ReqB;
  logic              LockB;
  logic [ADDR_W-1:0] AddrB;
  logic              WeB;
  logic [DATA_W-1:0] WDataB;
  logic              GntB;
  logic              RValidB;

  logic [ADDR_W-1:0] Mem_Address;
  logic              Mem_ReadEnable;
  logic              Mem_WriteEnable;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData;
  logic [DATA_W-1:0] RData;
  logic              Busy;

  // Arbiter side.
  modport slave (
    input  ReqA, LockA, AddrA, WeA, WDataA,
    input  ReqB, LockB, AddrB, WeB, WDataB,
    input  Mem_RData,
    output GntA, RValidA, GntB, RValidB,
    output Mem_Address, Mem_ReadEnable, Mem_WriteEnable, Mem_WData,
    output RData, Busy
  );

  // Requester / memory side.
  modport master (
    output ReqA, LockA, AddrA, WeA, WDataA,
    output ReqB, LockB, AddrB, WeB, WDataB,
    output Mem_RData,
    input  GntA, RValidA, GntB, RValidB,
    input  Mem_Address, Mem_ReadEnable, Mem_WriteEnable, Mem_WData,
    input  RData, Busy
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register routing read returns to their issuer.
module mem_rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic issue_rd,
  input  logic issue_owner,
  output logic RValidA,
  output logic RValidB,
  output logic busy
);

  rd_tag_t [RD_LAT-1:0] pipe_q;

  // Shift tags; reset drops every in-flight read so it never returns.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0].valid <= issue_rd;
      pipe_q[0].owner <= issue_owner;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Steer the final stage to the owning port and flag any read in flight.
  always_comb begin
    busy    = 1'b0;
    RValidA = pipe_q[RD_LAT-1].valid & (pipe_q[RD_LAT-1].owner == OWNER_A);
    RValidB = pipe_q[RD_LAT-1].valid & (pipe_q[RD_LAT-1].owner == OWNER_B);
    for (int i = 0; i < int'(RD_LAT); i++) begin
      busy = busy | pipe_q[i].valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port accumulator data memory.
// Port A: accumulation sequencer; port B: host loader/readback.
// Build option MEMARB_FIXED_PRIO_EN: A always wins in IDLE and only B is
// burst-limited; otherwise round-robin with a burst limit on both ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic              Clock,
  input logic              Reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d, burst_inc;
  logic                   own_a, own_b;
  logic                   issue_a, issue_b;
  logic                   at_limit;
  logic                   favour_b;
  logic                   limit_a_en;
  logic                   tag_busy;
  logic                   issue_owner;

  logic [ADDR_W-1:0]      mem_addr_c;
  logic [DATA_W-1:0]      mem_wdata_c;
  logic                   mem_re_c, mem_we_c;

  assign own_a   = (state_q == OWN_A);
  assign own_b   = (state_q == OWN_B);
  assign issue_a = own_a & bus.ReqA;
  assign issue_b = own_b & bus.ReqB;

  // Saturating so a long uncontended burst cannot wrap past the limit.
  assign burst_inc = ((issue_a | issue_b) && (burst_q != '1)) ? burst_q + BURST_CNT_W'(1)
                                                              : burst_q;
  assign at_limit  = (burst_inc >= BURST_CNT_W'(MAX_BURST));

`ifdef MEMARB_FIXED_PRIO_EN
  assign favour_b   = 1'b0;
  assign limit_a_en = 1'b0;
`else
  logic rr_q, rr_d;

  assign favour_b   = (rr_q == OWNER_B);
  assign limit_a_en = 1'b1;

  // Round-robin pointer register; starts favouring A.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rr_q <= OWNER_A;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Leaving an OWN state is always a release: favour the other port next.
  always_comb begin
    rr_d = rr_q;
    if (own_a && (state_d != OWN_A)) begin
      rr_d = OWNER_B;
    end else if (own_b && (state_d != OWN_B)) begin
      rr_d = OWNER_A;
    end
  end
`endif

  // Ownership state and burst counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Next ownership: grant from IDLE, release on drop or burst limit unless locked.
  always_comb begin
    state_d = state_q;
    burst_d = burst_inc;
    unique case (state_q)
      IDLE: begin
        if (bus.ReqA && (!bus.ReqB || !favour_b)) begin
          state_d = OWN_A;
        end else if (bus.ReqB) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!bus.LockA && (!bus.ReqA || (limit_a_en && at_limit && bus.ReqB))) begin
          state_d = bus.ReqB ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (!bus.LockB && (!bus.ReqB || (at_limit && bus.ReqA))) begin
          state_d = bus.ReqA ? OWN_A : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      burst_d = '0;
    end
  end

  // Memory pins follow the issuing owner; idle cycles drive zeros.
  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    if (issue_a) begin
      mem_addr_c  = bus.AddrA;
      mem_wdata_c = bus.WDataA;
      mem_re_c    = ~bus.WeA;
      mem_we_c    = bus.WeA;
    end else if (issue_b) begin
      mem_addr_c  = bus.AddrB;
      mem_wdata_c = bus.WDataB;
      mem_re_c    = ~bus.WeB;
      mem_we_c    = bus.WeB;
    end
  end

  assign issue_owner         = issue_b ? OWNER_B : OWNER_A;

  assign bus.Mem_Address     = mem_addr_c;
  assign bus.Mem_WData       = mem_wdata_c;
  assign bus.Mem_ReadEnable  = mem_re_c;
  assign bus.Mem_WriteEnable = mem_we_c;
  assign bus.RData           = bus.Mem_RData;
  assign bus.GntA            = own_a;
  assign bus.GntB            = own_b;
  assign bus.Busy            = (state_q != IDLE) | tag_busy;

  mem_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .Clock       (Clock),
    .Reset       (Reset),
    .issue_rd    (mem_re_c),
    .issue_owner (issue_owner),
    .RValidA     (bus.RValidA),
    .RValidB     (bus.RValidB),
    .busy        (tag_busy)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port accumulator data memory between two requesters.
  - Port A: the accumulation sequencer.
  - Port B: the host loader/readback path.
- Registered grant, round-robin fairness, optional per-owner lock, bounded burst length.
- Tags in-flight reads so each read-data-valid strobe returns to the requester that issued the read, even across an ownership handover.
- Sits between both requesters and the memory's address/ReadEnable/WriteEnable pins.

Parameters:
- ADDR_W, 6, memory address width (64 words).
- DATA_W, 16, memory data width.
- RD_LAT, 2, cycles from read issue to valid Mem_RData (1..4).
- MAX_BURST, 8, max accesses per ownership while the other port waits, unless locked (1..255).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqA  in  1  port A requests / issues an access this cycle.
- LockA  in  1  port A keeps ownership past release and burst limit.
- AddrA  in  ADDR_W  port A address.
- WeA  in  1  port A access is a write (1) or read (0).
- WDataA  in  DATA_W  port A write data.
- GntA  out  1  port A owns the memory (registered).
- RValidA  out  1  read data on RData belongs to port A.
- ReqB, LockB, AddrB, WeB, WDataB, GntB, RValidB: same as port A, for port B.
- Mem_Address  out  ADDR_W  memory address.
- Mem_ReadEnable  out  1  memory read strobe.
- Mem_WriteEnable  out  1  memory write strobe.
- Mem_WData  out  DATA_W  memory write data.
- Mem_RData  in  DATA_W  memory read data.
- RData  out  DATA_W  Mem_RData passed through, shared by both ports.
- Busy  out  1  memory owned or reads still in flight.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; GntA=GntB=0; RValidA=RValidB=0.
  - Tag pipeline cleared; burst count=0; round-robin pointer favours A.
  - All Mem_* outputs 0; Busy=0.
  - Reads in flight when reset asserts are discarded; no RValid ever appears for them.
- States: IDLE, OWN_A, OWN_B. Gnt is decoded directly from the state register.
- IDLE:
  - Only one of ReqA/ReqB high -> that port's OWN state.
  - Both high -> the port the round-robin pointer favours.
- Access issue:
  - An access issues in a cycle only when Gnt and Req of the same port are both high.
  - Mem_Address/Mem_WData/WE are muxed combinationally from the owner.
  - Mem_ReadEnable = issue & ~We; Mem_WriteEnable = issue & We.
  - With no issue, Mem_* = 0.
  - First access issues 1 cycle after Req rises from IDLE (grant latency 1).
- Release from OWN_x at a clock edge (Lock_x=0, and either Req_x=0 or the burst limit is hit):
  - Other port requesting -> OWN_other directly, no bubble cycle.
  - Otherwise -> IDLE.
  - Round-robin pointer is set to favour the other port.
- Burst limit:
  - Burst count increments per issued access and clears on any state change.
  - When the access that makes count==MAX_BURST issues, the other Req is high, and Lock_x=0, ownership transfers at that edge.
  - Lock_x=1 suppresses release even when Req_x=0; ownership is held idle.
- Requester rule: Gnt may fall while Req is still high. Only accesses issued with Gnt high count; the requester re-presents any unissued access.
- Read return:
  - An RD_LAT-deep shift register carries {valid, owner} for each issued read.
  - RValid_owner pulses exactly RD_LAT cycles after issue; RData = Mem_RData.
  - Reads issued just before a handover still return to their issuer.
  - Writes produce no RValid.
- Busy = (state != IDLE) | any valid tag in the pipeline.
- Simultaneous Req rise on both ports from IDLE: resolved by the pointer; the loser waits at most MAX_BURST accesses unless the winner holds Lock.

Optional Feature:
- MEMARB_FIXED_PRIO_EN:
  - Defined: the pointer is ignored. Port A always wins in IDLE, and the burst limit applies only to port B, so B yields to A after MAX_BURST. Port A keeps the memory until it releases.
  - Undefined: round-robin as above.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2);
  - the owner-ID constants (OWNER_A=1'b0, OWNER_B=1'b1);
  - default ADDR_W/DATA_W.
- One natural sub-module: mem_rd_tag_pipe, the RD_LAT-deep {valid, owner} shift register with async clear that generates RValidA/RValidB.

Test Plan:
- ReqA high from IDLE, WeA=0, AddrA=5 -> GntA=1 at t+1, Mem_ReadEnable=1 and Mem_Address=5 at t+1, RValidA=1 at t+1+RD_LAT (t+3), RValidB=0 throughout.
- ReqA and ReqB both high from reset -> GntA first. A holds Req for 20 reads with LockA=0 -> handover to B after 8 issued reads, no bubble. GntB for up to 8 accesses, then back to A.
- A issues reads at addresses 6 and 7, then drops ReqA while ReqB is high -> GntB the next cycle. RValidA pulses for both A reads, even while B owns the memory.
- LockA=1, ReqA=0 for 3 cycles, ReqB=1 -> GntA stays 1, no Mem strobes, GntB=0. LockA falls -> GntB=1 on the next cycle.
- Reset pulled low with 2 reads in flight -> all outputs 0 immediately; no RValid after Reset is released; Busy=0.
- With MEMARB_FIXED_PRIO_EN: B owns the memory, A requests -> B yields after its 8th access; A, once granted, never loses the grant while ReqA=1.
